stdsub_serial: RTL
==================

# stdsub_serial

Bit-serial subtract-with-borrow unit, the sequential counterpart to the library's combinational full adder. It computes DIFF = A − B − BIN LSB-first, one bit per clock, through a single borrow flip-flop. It sits beside the datapath adders as a low-area subtractor/comparator for multi-cycle compare and SBC operations, using a START/DONE handshake.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2).
- CLK  in  1  rising-edge clock; the only clock.
- RESET_N  in  1  synchronous, active-low reset; sampled on the CLK rising edge.
- START  in  1  request; accepted only in IDLE.
- A  in  WIDTH  minuend; sampled only on the accepting edge.
- B  in  WIDTH  subtrahend; sampled only on the accepting edge.
- BIN  in  1  borrow in; sampled only on the accepting edge.
- BUSY  out  1  high whenever state ≠ IDLE.
- DONE  out  1  one-cycle pulse; DIFF/BOUT/ZERO are valid in that cycle.
- DIFF  out  WIDTH  result, (A − B − BIN) mod 2^WIDTH.
- BOUT  out  1  borrow out; 1 iff A < B + BIN (unsigned).
- ZERO  out  1  1 iff DIFF == 0.

## Operation
- States are IDLE, SHIFT and FIN. The state is registered, with a log2(WIDTH)+1-bit bit counter.
- IDLE:
  - When START = 1, load shift registers SA←A and SB←B, set borrow register BR←BIN, clear counter CNT←0, and go to SHIFT.
  - When START = 0, stay in IDLE.
- SHIFT, each cycle:
  - Compute d = SA[0] ^ SB[0] ^ BR.
  - Compute BR ← (~SA[0] & SB[0]) | (~SA[0] & BR) | (SB[0] & BR).
  - Shift SA and SB right by 1.
  - Shift internal register SD right with d entering the MSB.
  - Increment CNT.
  - After the edge that processes bit WIDTH−1, go to FIN.
- FIN:
  - Load DIFF ← SD and BOUT ← BR, and set ZERO ← (SD == 0). All three are registered.
  - DONE = 1 for exactly this cycle.
  - The next edge always returns to IDLE.
- START is ignored in SHIFT and FIN. There is no queuing and the operands are not re-sampled.
- DIFF, BOUT and ZERO hold their last value from FIN until the next FIN. Partial results are never visible on the outputs.
- Arithmetic is unsigned and modulo 2^WIDTH. BIN = 1 with A = B gives all-ones and BOUT = 1.

## Timing
- Reset (RESET_N = 0 at an edge):
  - State goes to IDLE.
  - BUSY = 0, DONE = 0, DIFF = 0, BOUT = 0, ZERO = 1.
  - SA, SB, SD, BR and CNT are cleared.
- Reset has priority over START and over any state.
- Reset during SHIFT or FIN aborts the operation: no DONE pulse, and outputs take their reset values.
- Edge numbering, with START accepted at edge 0:
  - BUSY is high from edge 0 through edge WIDTH+1.
  - SHIFT occupies edges 1..WIDTH.
  - FIN is entered after edge WIDTH, so DONE = 1 and results are valid in the cycle following edge WIDTH.
  - IDLE is entered after edge WIDTH+1.
- Latency from START edge to the DONE cycle is WIDTH cycles of SHIFT plus 1, i.e. DONE rises WIDTH cycles after the accepting edge.
- Throughput is one operation per WIDTH+2 cycles. The earliest next accepting edge is edge WIDTH+2.
- START held high continuously starts back-to-back operations at edges 0, WIDTH+2, 2(WIDTH+2), and so on.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Basic subtract, WIDTH = 8: A = 0x5A, B = 0x3C, BIN = 0 → DIFF = 0x1E, BOUT = 0, ZERO = 0. DONE is seen exactly 8 cycles after the START edge and lasts exactly one cycle. BUSY is high for 10 edges.
- Underflow: A = 0x00, B = 0x01, BIN = 0 → DIFF = 0xFF, BOUT = 1. Also A = 0x00, B = 0x00, BIN = 1 → DIFF = 0xFF, BOUT = 1, ZERO = 0.
- Zero and borrow-in: A = 0x80, B = 0x7F, BIN = 1 → DIFF = 0x00, BOUT = 0, ZERO = 1. Then A = 0xFF, B = 0xFF, BIN = 0 → DIFF = 0x00, BOUT = 0, ZERO = 1.
- START ignored while BUSY: start A = 0x10, B = 0x01. Pulse START with A = 0xAA, B = 0x55 at SHIFT cycle 3 and again in FIN → single DONE with DIFF = 0x0F. Outputs hold 0x0F until the next accepted operation.
- Reset mid-operation: assert RESET_N = 0 at SHIFT cycle 4 → no DONE, BUSY = 0, DIFF = 0, BOUT = 0, ZERO = 1 on the next cycle. A new START then completes normally with correct values.
- Randomized back-to-back: START held high, 1000 random A/B/BIN with WIDTH = 8 and WIDTH = 13, compared against the model (A − B − BIN) mod 2^WIDTH and BOUT = (A < B + BIN). Check the DONE spacing is exactly WIDTH+2 cycles.

Source files
------------

// File: rtl/stdsub_serial_if.sv
// Request/result bundle for the bit-serial subtractor: operands and START in,
// BUSY/DONE handshake and the registered DIFF/BOUT/ZERO result out.
interface stdsub_serial_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             zero;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout, zero
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout, zero
   );
endinterface

// File: rtl/stdsub_serial.sv
// Bit-serial subtract-with-borrow: DIFF = A - B - BIN, LSB first, one bit per
// clock through a single borrow flop, with a START/DONE handshake.
module stdsub_serial #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           reset_n,
   stdsub_serial_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FIN
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] sd;
   logic             br;
   logic [CW-1:0]    cnt;

   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;
   logic             zero_q;

   logic             d_bit;
   logic             br_next;
   logic [WIDTH-1:0] sd_next;

   // Full-subtractor cell applied to the current LSB pair and stored borrow.
   assign d_bit   = sa[0] ^ sb[0] ^ br;
   assign br_next = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br);
   assign sd_next = {d_bit, sd[WIDTH-1:1]};

   // The result registers are loaded on the edge that enters FIN, so they are
   // already valid during the DONE cycle and hold until the next completion.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state  <= IDLE;
         sa     <= '0;
         sb     <= '0;
         sd     <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         diff_q <= '0;
         bout_q <= 1'b0;
         zero_q <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  sa     <= bus.a;
                  sb     <= bus.b;
                  br     <= bus.bin;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               sd  <= sd_next;
               br  <= br_next;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  diff_q <= sd_next;
                  bout_q <= br_next;
                  zero_q <= (sd_next == '0);
                  done_q <= 1'b1;
                  state  <= FIN;
               end
            end
            FIN: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
   assign bus.zero = zero_q;
endmodule
